aq_djpeg_dqt_parser: RTL and testbench

Parses the payload of a JPEG DQT marker segment (the bytes after FFDB) and turns it into the quantization-table write stream that fills the DQT table RAM. It sits between the marker/header byte sequencer and the DQT table RAM. It handles one or more tables per segment, supports baseline 8-bit precision only, and rejects malformed segments with an error flag.

---
 rtl/aq_djpeg_dqt_parser.sv | 165 ++++++++++++++++
 tb/tb_aq_djpeg_dqt_parser.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_dqt_parser.sv
// JPEG DQT segment payload parser: walks Lq / Pq,Tq / 64-entry tables and
// emits a registered quantization-table write stream, flagging malformed segments.
module aq_djpeg_dqt_parser (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic       ByteValid,
  input  logic [7:0] ByteData,
  output logic       ByteReady,
  output logic       DataInEnable,
  output logic       DataInColor,
  output logic [5:0] DataInCount,
  output logic [7:0] DataIn,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_H,
    LEN_L,
    PQTQ,
    TABLE,
    SKIP,
    DONE
  } stateType;

  stateType    state;
  stateType    stateNext;
  logic [7:0]  lenHigh;
  logic [15:0] remCount;
  logic [15:0] remDec;
  logic [15:0] lqValue;
  logic [5:0]  entryCount;
  logic        tableColor;
  logic        setError;
  logic        accept;

  assign accept  = ByteValid && ByteReady;
  assign lqValue = {lenHigh, ByteData};
  assign remDec  = (remCount != 16'd0) ? remCount - 16'd1 : remCount;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    setError  = 1'b0;
    ByteReady = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    unique case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) stateNext = LEN_H;
      end
      LEN_H: begin
        ByteReady = 1'b1;
        if (ByteValid) stateNext = LEN_L;
      end
      LEN_L: begin
        ByteReady = 1'b1;
        if (ByteValid) begin
          if (lqValue < 16'd2) begin
            setError  = 1'b1;
            stateNext = DONE;
          end else if (lqValue == 16'd2) begin
            stateNext = DONE;
          end else begin
            stateNext = PQTQ;
          end
        end
      end
      PQTQ: begin
        ByteReady = 1'b1;
        // A table needs this byte plus 64 entries still inside the segment
        if (ByteValid) begin
          if ((ByteData[7:4] != 4'd0) || (ByteData[3:0] > 4'd1) || (remCount < 16'd65)) begin
            setError  = 1'b1;
            stateNext = SKIP;
          end else begin
            stateNext = TABLE;
          end
        end
      end
      TABLE: begin
        ByteReady = 1'b1;
        if (ByteValid && (entryCount == 6'd63)) begin
          stateNext = (remDec == 16'd0) ? DONE : PQTQ;
        end
      end
      SKIP: begin
        ByteReady = 1'b1;
        if (remCount == 16'd0) begin
          stateNext = DONE;
        end else if (ByteValid && (remCount == 16'd1)) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        Busy      = 1'b0;
        Done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Length/entry bookkeeping plus the registered table write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lenHigh      <= 8'd0;
      remCount     <= 16'd0;
      entryCount   <= 6'd0;
      tableColor   <= 1'b0;
      Error        <= 1'b0;
      DataInEnable <= 1'b0;
      DataInColor  <= 1'b0;
      DataInCount  <= 6'd0;
      DataIn       <= 8'd0;
    end else begin
      DataInEnable <= 1'b0;
      if ((state == IDLE) && Start) Error <= 1'b0;
      if (setError) Error <= 1'b1;
      unique case (state)
        LEN_H: begin
          if (accept) lenHigh <= ByteData;
        end
        LEN_L: begin
          if (accept) remCount <= (lqValue < 16'd2) ? 16'd0 : lqValue - 16'd2;
        end
        PQTQ: begin
          if (accept) begin
            remCount <= remDec;
            if (!setError) begin
              tableColor <= ByteData[0];
              entryCount <= 6'd0;
            end
          end
        end
        TABLE: begin
          if (accept) begin
            remCount     <= remDec;
            entryCount   <= entryCount + 6'd1;
            DataInEnable <= 1'b1;
            DataInColor  <= tableColor;
            DataInCount  <= entryCount;
            DataIn       <= ByteData;
          end
        end
        SKIP: begin
          if (accept) remCount <= remDec;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_djpeg_dqt_parser.sv
// Table-driven bench for aq_djpeg_dqt_parser: whole DQT segments are driven per
// vector and the captured write stream, Done timing and Error are compared.
module tb_aq_djpeg_dqt_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Start = 1'b0;
  logic       ByteValid = 1'b0;
  logic [7:0] ByteData = 8'd0;
  logic       ByteReady;
  logic       DataInEnable;
  logic       DataInColor;
  logic [5:0] DataInCount;
  logic [7:0] DataIn;
  logic       Busy;
  logic       Done;
  logic       Error;

  aq_djpeg_dqt_parser dut (
    .clk(clk),
    .rst(rst),
    .Start(Start),
    .ByteValid(ByteValid),
    .ByteData(ByteData),
    .ByteReady(ByteReady),
    .DataInEnable(DataInEnable),
    .DataInColor(DataInColor),
    .DataInCount(DataInCount),
    .DataIn(DataIn),
    .Busy(Busy),
    .Done(Done),
    .Error(Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [15:0] lq;
    int         nTables;
    logic [7:0] pqtqA;
    logic [7:0] baseA;
    int         lenA;
    logic [7:0] pqtqB;
    logic [7:0] baseB;
    int         lenB;
    int         validTables;
    bit         expError;
    int         doneDelay;
    bit         gaps;
    int         startAt;
    bit         startInDone;
  } vecType;

  vecType      vecs[$];
  logic [7:0]  txBytes[$];
  logic [14:0] wrQ[$];
  int          doneQ[$];
  int          timingBad = 0;
  bit          hsPrev = 1'b0;
  int          cycleCount = 0;
  int          lastEdge = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Capture writes and Done away from the active edge; a write must follow a handshake
  always @(negedge clk) begin
    if (DataInEnable) begin
      wrQ.push_back({DataInColor, DataInCount, DataIn});
      if (!hsPrev) timingBad = timingBad + 1;
    end
    if (Done) doneQ.push_back(cycleCount);
    hsPrev = ByteValid && ByteReady;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input logic [15:0] lq, input int nTables,
                        input logic [7:0] pqtqA, input logic [7:0] baseA, input int lenA,
                        input logic [7:0] pqtqB, input logic [7:0] baseB, input int lenB,
                        input int validTables, input bit expError, input int doneDelay,
                        input bit gaps, input int startAt, input bit startInDone);
    vecType v;
    v.name = name; v.lq = lq; v.nTables = nTables;
    v.pqtqA = pqtqA; v.baseA = baseA; v.lenA = lenA;
    v.pqtqB = pqtqB; v.baseB = baseB; v.lenB = lenB;
    v.validTables = validTables; v.expError = expError; v.doneDelay = doneDelay;
    v.gaps = gaps; v.startAt = startAt; v.startInDone = startInDone;
    vecs.push_back(v);
  endtask

  task automatic buildBytes(input vecType v);
    txBytes.delete();
    txBytes.push_back(v.lq[15:8]);
    txBytes.push_back(v.lq[7:0]);
    if (v.nTables >= 1) begin
      txBytes.push_back(v.pqtqA);
      for (int i = 0; i < v.lenA; i++) txBytes.push_back(8'(v.baseA + i));
    end
    if (v.nTables >= 2) begin
      txBytes.push_back(v.pqtqB);
      for (int i = 0; i < v.lenB; i++) txBytes.push_back(8'(v.baseB + i));
    end
  endtask

  task automatic clearMon();
    wrQ.delete();
    doneQ.delete();
    timingBad = 0;
  endtask

  task automatic pulseStart();
    @(posedge clk); #1;
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic driveBytes(input int count, input bit gaps, input int startAt, output int sent);
    int  idx;
    int  guard;
    bit  acc;
    idx = 0;
    guard = 0;
    while ((idx < count) && (guard < 3000)) begin
      ByteValid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      ByteData  = txBytes[idx];
      Start     = (idx == startAt);
      acc = ByteValid && ByteReady;
      @(posedge clk); #1;
      if (acc) begin
        idx = idx + 1;
        lastEdge = cycleCount;
      end
      guard = guard + 1;
    end
    ByteValid = 1'b0;
    ByteData  = 8'd0;
    Start     = 1'b0;
    sent = idx;
  endtask

  task automatic checkResults(input vecType v, input int expDone);
    logic [14:0] exp;
    int          nWrites;
    nWrites = 64 * v.validTables;
    checkOutput({v.name, ":writeCount"}, 32'(wrQ.size()), 32'(nWrites));
    for (int i = 0; (i < wrQ.size()) && (i < nWrites); i++) begin
      if (i < 64) exp = {v.pqtqA[0], 6'(i), 8'(v.baseA + i)};
      else        exp = {v.pqtqB[0], 6'(i - 64), 8'(v.baseB + i - 64)};
      checkOutput($sformatf("%s:write%0d", v.name, i), 32'(wrQ[i]), 32'(exp));
    end
    checkOutput({v.name, ":writeTiming"}, 32'(timingBad), 32'd0);
    checkOutput({v.name, ":doneCount"}, 32'(doneQ.size()), 32'd1);
    checkOutput({v.name, ":doneCycle"}, (doneQ.size() > 0) ? 32'(doneQ[0]) : 32'hFFFF_FFFF, 32'(expDone));
    checkOutput({v.name, ":error"}, 32'(Error), 32'(v.expError));
    checkOutput({v.name, ":idle"}, 32'({Busy, ByteReady, Done, DataInEnable}), 32'd0);
  endtask

  task automatic applyStimulus(input vecType v);
    int sent;
    buildBytes(v);
    clearMon();
    pulseStart();
    checkOutput({v.name, ":startBusy"}, 32'({Busy, Error, ByteReady}), 32'b101);
    driveBytes(txBytes.size(), v.gaps, v.startAt, sent);
    checkOutput({v.name, ":consumed"}, 32'(sent), 32'(txBytes.size()));
    if (v.startInDone) begin
      Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    checkResults(v, lastEdge + v.doneDelay);
  endtask

  initial begin
    vecType cTable;
    int     sent;

    addVec("twoTables",   16'h0084, 2, 8'h00, 8'h01, 64, 8'h01, 8'h80, 64, 2, 1'b0, 0, 1'b0, -1, 1'b0);
    addVec("pqError",     16'h0043, 1, 8'h11, 8'h00, 64, 8'h00, 8'h00, 0,  0, 1'b1, 0, 1'b0, -1, 1'b0);
    addVec("tqError",     16'h0043, 1, 8'h02, 8'h00, 64, 8'h00, 8'h00, 0,  0, 1'b1, 0, 1'b0, -1, 1'b0);
    addVec("lenOne",      16'h0001, 0, 8'h00, 8'h00, 0,  8'h00, 8'h00, 0,  0, 1'b1, 0, 1'b0, -1, 1'b0);
    addVec("lenTwo",      16'h0002, 0, 8'h00, 8'h00, 0,  8'h00, 8'h00, 0,  0, 1'b0, 0, 1'b0, -1, 1'b1);
    addVec("lenZero",     16'h0000, 0, 8'h00, 8'h00, 0,  8'h00, 8'h00, 0,  0, 1'b1, 0, 1'b0, -1, 1'b0);
    addVec("yGaps",       16'h0043, 1, 8'h00, 8'h01, 64, 8'h00, 8'h00, 0,  1, 1'b0, 0, 1'b1, -1, 1'b0);
    addVec("cStartBusy",  16'h0043, 1, 8'h01, 8'h40, 64, 8'h00, 8'h00, 0,  1, 1'b0, 0, 1'b0, 20, 1'b0);
    addVec("shortTable",  16'h0013, 1, 8'h00, 8'h00, 16, 8'h00, 8'h00, 0,  0, 1'b1, 0, 1'b0, -1, 1'b0);
    addVec("shortSecond", 16'h004E, 2, 8'h00, 8'h10, 64, 8'h01, 8'h00, 10, 1, 1'b1, 0, 1'b0, -1, 1'b0);
    addVec("remZeroSkip", 16'h0003, 1, 8'h00, 8'h00, 0,  8'h00, 8'h00, 0,  0, 1'b1, 1, 1'b0, -1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetState",
                32'({ByteReady, DataInEnable, DataInColor, DataInCount, DataIn, Busy, Done, Error}), 32'd0);
    rst = 1'b1;

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Reset in the middle of a Y table, then a fresh C table must start cleanly at idx 0
    cTable = vecs[0];
    cTable.name = "midResetY"; cTable.lq = 16'h0043; cTable.nTables = 1;
    cTable.pqtqA = 8'h00; cTable.baseA = 8'h20; cTable.lenA = 64;
    buildBytes(cTable);
    clearMon();
    pulseStart();
    driveBytes(13, 1'b0, -1, sent);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("midReset:outputs",
                32'({ByteReady, DataInEnable, DataInColor, DataInCount, DataIn, Busy, Done, Error}), 32'd0);
    ByteValid = 1'b1;
    ByteData  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    ByteValid = 1'b0;
    rst = 1'b1;
    checkOutput("midReset:partialWrites", 32'(wrQ.size()), 32'd10);
    checkOutput("midReset:lastWrite", (wrQ.size() > 9) ? 32'(wrQ[9]) : 32'hFFFF_FFFF,
                32'({1'b0, 6'd9, 8'h29}));

    cTable.name = "afterReset"; cTable.pqtqA = 8'h01; cTable.baseA = 8'hC0;
    cTable.validTables = 1; cTable.expError = 1'b0; cTable.doneDelay = 0;
    cTable.gaps = 1'b0; cTable.startAt = -1; cTable.startInDone = 1'b0;
    applyStimulus(cTable);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
